// File: rtl/lvds_tx_serializer.sv
// Parallel-to-serial LVDS transmitter: start bit, DW data bits LSB first,
// even parity, stop bit, with every serial bit held for CLK_DIV clocks.
//
// state   | meaning
// IDLE    | line high, waiting for a tx_ena strobe
// START   | line low for one bit period
// DATA    | shifting out DW data bits, LSB first
// PARITY  | even parity of the captured word
// STOP    | line high; tx_done pulses as the FSM returns to IDLE
module lvds_tx_serializer #(
    parameter int CLK_DIV = 4,
    parameter int DW      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_ena,
    input  logic [DW-1:0] data_in,
    output logic          tx_busy,
    output logic          lvds_dat,
    output logic          lvds_frm,
    output logic          tx_done
);

    localparam int            BW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [7:0]    DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [BW-1:0] r_bit;
    logic [BW-1:0] w_bit_nxt;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] w_shift_nxt;
    logic          r_par;
    logic          w_par_nxt;
    logic          w_tc;
    logic          w_dat_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Bit-period down-counter reaches terminal count on the last clock of a bit.
    assign w_tc = (r_cnt == 8'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;

        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_tc ? DIV_LOAD : (r_cnt - 8'd1);
        end

        case (r_state)
            ST_IDLE: begin
                if (tx_ena) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = DIV_LOAD;
                    w_shift_nxt = data_in;
                    w_par_nxt   = ^data_in;
                end
            end
            ST_START: begin
                if (w_tc) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_bit_nxt   = r_bit + BW'(1);
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tc) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state register rather than lagging it by a cycle.
    always_comb begin
        w_dat_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_dat_nxt = 1'b0;
            ST_DATA:   w_dat_nxt = w_shift_nxt[0];
            ST_PARITY: w_dat_nxt = w_par_nxt;
            default:   w_dat_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            tx_busy  <= 1'b0;
            lvds_dat <= 1'b1;
            lvds_frm <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            tx_busy  <= w_busy_nxt;
            lvds_dat <= w_dat_nxt;
            lvds_frm <= w_busy_nxt;
            tx_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Directed + random bench for lvds_tx_serializer: a deserializing monitor
// checks every frame against a queue of strobed words.
module tb_lvds_tx_serializer;

    localparam int DW  = 24;
    localparam int DIV = 4;
    localparam int FL  = (DW + 3) * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_ena;
    logic [DW-1:0] data_in;
    logic          tx_busy, lvds_dat, lvds_frm, tx_done;
    logic          tx_ena2;
    logic [DW-1:0] data_in2;
    logic          tx_busy2, lvds_dat2, lvds_frm2, tx_done2;

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int done2_cnt = 0;
    int exp_done  = 0;
    logic [DW-1:0] sb[$];

    lvds_tx_serializer #(.CLK_DIV(DIV), .DW(DW)) dut (
        .clk(clk), .rst(rst), .tx_ena(tx_ena), .data_in(data_in),
        .tx_busy(tx_busy), .lvds_dat(lvds_dat), .lvds_frm(lvds_frm), .tx_done(tx_done)
    );

    lvds_tx_serializer #(.CLK_DIV(2), .DW(DW)) dut2 (
        .clk(clk), .rst(rst), .tx_ena(tx_ena2), .data_in(data_in2),
        .tx_busy(tx_busy2), .lvds_dat(lvds_dat2), .lvds_frm(lvds_frm2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_done2 === 1'b1) done2_cnt++;
    end

    // Deserializing monitor for the CLK_DIV=4 instance.
    int            m_k = 0, m_busy = 0, m_gap = 0, m_last_gap = 0;
    bit            m_in = 0, m_unstable = 0;
    logic          m_pv;
    logic [DW+2:0] m_bits;
    logic [DW-1:0] m_w;

    always @(negedge clk) begin
        if (rst) begin
            m_in = 0;
            m_k  = 0;
        end else if (m_in && !lvds_frm) begin
            m_in  = 0;
            m_gap = 1;
            chk("frame_len", m_k, FL);
            chk("busy_len", m_busy, FL);
            chk("start_bit", m_bits[0], 0);
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                m_w = sb.pop_front();
                chk("data_word", m_bits[DW:1], m_w);
                chk("parity_bit", m_bits[DW+1], ^m_w);
            end
            chk("stop_bit", m_bits[DW+2], 1);
            chk("bit_stable", m_unstable, 0);
            chk("done_at_end", tx_done, 1);
            chk("busy_at_end", tx_busy, 0);
        end else if (!m_in && lvds_frm) begin
            m_in       = 1;
            m_k        = 0;
            m_busy     = 0;
            m_unstable = 0;
            m_bits     = '0;
            m_last_gap = m_gap;
        end else if (!m_in) begin
            m_gap++;
        end
        if (m_in) begin
            if (m_k % DIV == 0) m_pv = lvds_dat;
            else if (lvds_dat !== m_pv) m_unstable = 1;
            if ((m_k % DIV == DIV / 2) && (m_k / DIV <= DW + 2)) m_bits[m_k/DIV] = lvds_dat;
            if (tx_busy === 1'b1) m_busy++;
            m_k++;
        end
    end

    // Caller is between edges; the word is captured on the next posedge.
    task automatic strobe(input logic [DW-1:0] w);
        tx_ena  = 1'b1;
        data_in = w;
        @(posedge clk);
        #1 tx_ena = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done !== 1'b1 && n < 400);
        chk(tag, tx_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            k, busy2, g, d0;
        logic [DW+2:0] b2;
        logic [DW-1:0] w;

        tx_ena = 0; data_in = '0; tx_ena2 = 0; data_in2 = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", tx_busy, 0);
        chk("rst_dat", lvds_dat, 1);
        chk("rst_frm", lvds_frm, 0);
        chk("rst_done", tx_done, 0);
        chk("rst2_dat", lvds_dat2, 1);
        chk("rst2_frm", lvds_frm2, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single word 0x0000F2
        sb.push_back(24'h0000F2);
        strobe(24'h0000F2);
        chk("busy_after_capture", tx_busy, 1);
        chk("frm_after_capture", lvds_frm, 1);
        chk("dat_start", lvds_dat, 0);
        wait_done("done_f2");
        exp_done++;
        @(negedge clk);
        chk("done_one_cycle", tx_done, 0);
        chk("done_cnt_f2", done_cnt, exp_done);

        // Back-to-back: second word strobed in the tx_done cycle
        sb.push_back(24'h00000A);
        strobe(24'h00000A);
        wait_done("done_0a");
        exp_done++;
        sb.push_back(24'hA5A5A5);
        strobe(24'hA5A5A5);
        chk("b2b_busy", tx_busy, 1);
        @(negedge clk);
        #1 chk("b2b_gap", m_last_gap, 1);
        wait_done("done_a5");
        exp_done++;

        // tx_ena ignored while busy
        repeat (5) @(negedge clk);
        sb.push_back(24'h3C0F96);
        strobe(24'h3C0F96);
        repeat (49) @(posedge clk);
        #1 tx_ena = 1'b1; data_in = 24'hFFFFFF;
        @(posedge clk);
        #1 tx_ena = 1'b0;
        wait_done("done_ignore");
        exp_done++;
        repeat (20) @(negedge clk);
        chk("ignore_no_frame", lvds_frm, 0);
        chk("ignore_sb_empty", sb.size(), 0);
        chk("ignore_done_cnt", done_cnt, exp_done);

        // tx_ena held high across capture yields a single frame
        sb.push_back(24'h5A5A01);
        tx_ena = 1'b1; data_in = 24'h5A5A01;
        repeat (3) @(posedge clk);
        #1 tx_ena = 1'b0;
        wait_done("done_hold");
        exp_done++;
        repeat (10) @(negedge clk);
        chk("hold_no_frame", lvds_frm, 0);
        chk("hold_sb_empty", sb.size(), 0);

        // Mid-frame reset during DATA bit 10
        d0 = done_cnt;
        strobe(24'h123456);
        repeat (45) @(posedge clk);
        #1 chk("pre_rst_frm", lvds_frm, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_dat", lvds_dat, 1);
        chk("arst_frm", lvds_frm, 0);
        chk("arst_busy", tx_busy, 0);
        chk("arst_done", tx_done, 0);
        tx_ena = 1'b1; data_in = 24'h777777;
        @(posedge clk);
        #1 tx_ena = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("no_capture_in_rst", tx_busy, 0);
        chk("abort_no_done", done_cnt, d0);
        sb.push_back(24'h654321);
        strobe(24'h654321);
        wait_done("done_after_rst");
        exp_done++;

        // CLK_DIV=2 instance, 0x800001
        @(negedge clk);
        tx_ena2 = 1'b1; data_in2 = 24'h800001;
        @(posedge clk);
        #1 tx_ena2 = 1'b0;
        data_in2 = 24'h0F0F0F;
        k = 0; busy2 = 0; b2 = '0;
        while (k < 200) begin
            @(negedge clk);
            if (!lvds_frm2) break;
            if (tx_busy2) busy2++;
            if ((k % 2 == 1) && (k / 2 <= DW + 2)) b2[k/2] = lvds_dat2;
            k++;
        end
        chk("div2_len", k, 54);
        chk("div2_busy", busy2, 54);
        chk("div2_start", b2[0], 0);
        chk("div2_bit0", b2[1], 1);
        chk("div2_bit23", b2[DW], 1);
        chk("div2_word", b2[DW:1], 24'h800001);
        chk("div2_parity", b2[DW+1], 0);
        chk("div2_stop", b2[DW+2], 1);
        chk("div2_done_now", tx_done2, 1);
        @(negedge clk);
        chk("div2_done_cnt", done2_cnt, 1);

        // 200 random words with random idle gaps
        repeat (3) @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            w = DW'($urandom);
            sb.push_back(w);
            strobe(w);
            data_in = DW'($urandom);
            @(negedge clk);
            #1;
            if (i > 0) chk("rand_gap", m_last_gap, g + 1);
            wait_done("done_rand");
            exp_done++;
            g = $urandom_range(0, 4);
            repeat (g) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_done_cnt", done_cnt, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
